// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Registered control sequencer for the CPU instruction cycle
//            (FETCH -> EXEC1 -> [EXEC2] -> FETCH). It adds a memory-ready
//            handshake in FETCH, repeated EXEC1 cycles for iterative
//            instructions, a HALT state with resume, and a fetch watchdog
//            that halts with a sticky fault flag.
// Ports    :
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   mem_ready    in   instruction data valid (looked at only in FETCH)
//   extra        in   instruction needs EXEC2 (first EXEC1 cycle)
//   loop_req     in   instruction is iterative (first EXEC1 cycle)
//   loop_init    in   total EXEC1 cycles for an iterative instruction
//   halt_req     in   halt instruction (first EXEC1 cycle)
//   run          in   resume request (looked at only in HALT)
//   state        out  FETCH=000 EXEC1=001 EXEC2=010 HALT=100
//   fetch/exec1/exec2/halted  out  one-hot decodes of state
//   mem_req      out  memory request, equal to fetch
//   ir_load      out  fetch & mem_ready
//   pc_inc       out  fetch & mem_ready
//   loop_active  out  high on repeat EXEC1 cycles
//   loop_cnt     out  remaining EXEC1 cycles
//   fault        out  sticky watchdog fault
// Revision : 1.0  initial release
// ============================================================================
module cpu_sequencer #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_ready,
  input  logic             extra,
  input  logic             loop_req,
  input  logic [CNT_W-1:0] loop_init,
  input  logic             halt_req,
  input  logic             run,
  output logic [2:0]       state,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic             halted,
  output logic             mem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             loop_active,
  output logic [CNT_W-1:0] loop_cnt,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_FETCH = 3'b000,
    S_EXEC1 = 3'b001,
    S_EXEC2 = 3'b010,
    S_HALT  = 3'b100
  } state_t;

  // Last wait count before the watchdog trips.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] loop_cnt_q, loop_cnt_d;
  logic             loop_active_q, loop_active_d;
  logic             extra_q, extra_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      loop_cnt_q    <= '0;
      loop_active_q <= 1'b0;
      extra_q       <= 1'b0;
      wait_cnt_q    <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      loop_cnt_q    <= loop_cnt_d;
      loop_active_q <= loop_active_d;
      extra_q       <= extra_d;
      wait_cnt_q    <= wait_cnt_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    loop_cnt_d    = loop_cnt_q;
    loop_active_d = loop_active_q;
    extra_d       = extra_q;
    wait_cnt_d    = wait_cnt_q;
    fault_d       = fault_q;

    case (state_q)
      S_FETCH: begin
        // A ready memory wins even in the cycle the watchdog would trip.
        if (mem_ready) begin
          wait_cnt_d = '0;
          state_d    = S_EXEC1;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          wait_cnt_d = '0;
          fault_d    = 1'b1;
          state_d    = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_EXEC1: begin
        if (!loop_active_q) begin
          // First EXEC1 cycle: decode; priority halt > loop > extra.
          extra_d = extra;
          if (halt_req) begin
            state_d = S_HALT;
          end else if (loop_req && (loop_init > CNT_ONE)) begin
            loop_cnt_d    = loop_init - CNT_ONE;
            loop_active_d = 1'b1;
          end else begin
            state_d = extra ? S_EXEC2 : S_FETCH;
          end
        end else begin
          // Repeat cycles ignore the decode inputs and use the latched extra.
          loop_cnt_d = loop_cnt_q - CNT_ONE;
          if (loop_cnt_q == CNT_ONE) begin
            loop_active_d = 1'b0;
            state_d       = extra_q ? S_EXEC2 : S_FETCH;
          end
        end
      end

      S_EXEC2: begin
        extra_d = 1'b0;
        state_d = S_FETCH;
      end

      S_HALT: begin
        if (run) begin
          fault_d    = 1'b0;
          wait_cnt_d = '0;
          state_d    = S_FETCH;
        end
      end

      default: begin
        state_d       = S_FETCH;
        loop_active_d = 1'b0;
      end
    endcase
  end

  assign state       = state_q;
  assign fetch       = (state_q == S_FETCH);
  assign exec1       = (state_q == S_EXEC1);
  assign exec2       = (state_q == S_EXEC2);
  assign halted      = (state_q == S_HALT);
  assign mem_req     = fetch;
  assign ir_load     = fetch & mem_ready;
  assign pc_inc      = fetch & mem_ready;
  assign loop_active = loop_active_q;
  assign loop_cnt    = loop_cnt_q;
  assign fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Directed self-checking bench for cpu_sequencer with
//            hand-computed expected values.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_ready;
  logic             extra;
  logic             loop_req;
  logic [CNT_W-1:0] loop_init;
  logic             halt_req;
  logic             run;
  logic [2:0]       state;
  logic             fetch, exec1, exec2, halted;
  logic             mem_req, ir_load, pc_inc;
  logic             loop_active;
  logic [CNT_W-1:0] loop_cnt;
  logic             fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_ready   (mem_ready),
    .extra       (extra),
    .loop_req    (loop_req),
    .loop_init   (loop_init),
    .halt_req    (halt_req),
    .run         (run),
    .state       (state),
    .fetch       (fetch),
    .exec1       (exec1),
    .exec2       (exec2),
    .halted      (halted),
    .mem_req     (mem_req),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .loop_active (loop_active),
    .loop_cnt    (loop_cnt),
    .fault       (fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; resume 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are settled one unit before the checks so combinational outputs are stable.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; extra = 1'b0; loop_req = 1'b0;
    loop_init = '0; halt_req = 1'b0; run = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
    // Reset state
    chk("rst_state",   32'(state), 32'h0);
    chk("rst_fetch",   32'(fetch), 32'h1);
    chk("rst_memreq",  32'(mem_req), 32'h1);
    chk("rst_irload",  32'(ir_load), 32'h0);
    chk("rst_halted",  32'(halted), 32'h0);
    chk("rst_lact",    32'(loop_active), 32'h0);
    chk("rst_lcnt",    32'(loop_cnt), 32'h0);
    chk("rst_fault",   32'(fault), 32'h0);

    // Basic 2-cycle instructions: 000,001,000,001
    mem_ready = 1'b1;
    settle();
    chk("b_s0",      32'(state), 32'h0);
    chk("b_irload0", 32'(ir_load), 32'h1);
    chk("b_pcinc0",  32'(pc_inc), 32'h1);
    tick(); chk("b_s1", 32'(state), 32'h1);
    chk("b_irload1", 32'(ir_load), 32'h0);
    tick(); chk("b_s2", 32'(state), 32'h0);
    chk("b_irload2", 32'(ir_load), 32'h1);
    tick(); chk("b_s3", 32'(state), 32'h1);
    tick(); chk("b_s4", 32'(state), 32'h0);
    chk("b_fault", 32'(fault), 32'h0);

    // extra=1: 000,001,010,000
    extra = 1'b1;
    tick(); chk("x_s1", 32'(state), 32'h1);
    tick(); chk("x_s2", 32'(state), 32'h2);
    chk("x_exec2", 32'(exec2), 32'h1);
    extra = 1'b0;
    tick(); chk("x_s3", 32'(state), 32'h0);
    chk("x_exec2_off", 32'(exec2), 32'h0);

    // Loop: loop_init=4, extra=1 -> EXEC1 x4 (cnt 3,2,1), EXEC2, FETCH
    loop_req = 1'b1; loop_init = 4'd4; extra = 1'b1;
    tick(); chk("l_first", 32'(state), 32'h1);
    chk("l_first_act", 32'(loop_active), 32'h0);
    tick();
    // Decode inputs now ignored; run must also be ignored outside HALT.
    loop_req = 1'b0; loop_init = 4'd0; extra = 1'b0; run = 1'b1;
    settle();
    chk("l_r1_state", 32'(state), 32'h1);
    chk("l_r1_act",   32'(loop_active), 32'h1);
    chk("l_r1_cnt",   32'(loop_cnt), 32'h3);
    tick(); run = 1'b0;
    chk("l_r2_state", 32'(state), 32'h1);
    chk("l_r2_act",   32'(loop_active), 32'h1);
    chk("l_r2_cnt",   32'(loop_cnt), 32'h2);
    tick();
    chk("l_r3_state", 32'(state), 32'h1);
    chk("l_r3_act",   32'(loop_active), 32'h1);
    chk("l_r3_cnt",   32'(loop_cnt), 32'h1);
    tick();
    chk("l_exec2",    32'(state), 32'h2);
    chk("l_end_act",  32'(loop_active), 32'h0);
    chk("l_end_cnt",  32'(loop_cnt), 32'h0);
    tick();
    chk("l_fetch",    32'(state), 32'h0);

    // Watchdog: 16 FETCH cycles without mem_ready, then HALT with fault
    mem_ready = 1'b0;
    settle();
    chk("t_irload0", 32'(ir_load), 32'h0);
    for (int i = 2; i <= TIMEOUT; i++) begin
      tick();
      chk($sformatf("t_fetch%0d", i), 32'(state), 32'h0);
    end
    tick();
    chk("t_halt",    32'(state), 32'h4);
    chk("t_halted",  32'(halted), 32'h1);
    chk("t_fault",   32'(fault), 32'h1);
    chk("t_memreq",  32'(mem_req), 32'h0);
    mem_ready = 1'b1;
    settle();
    chk("t_h_irload", 32'(ir_load), 32'h0);
    chk("t_h_pcinc",  32'(pc_inc), 32'h0);
    tick();
    chk("t_h_stay", 32'(state), 32'h4);
    mem_ready = 1'b0; run = 1'b1;
    tick(); run = 1'b0;
    chk("t_resume",  32'(state), 32'h0);
    chk("t_fault0",  32'(fault), 32'h0);

    // mem_ready arrives on the 16th FETCH cycle: EXEC1, no fault
    for (int i = 2; i <= TIMEOUT; i++) begin
      tick();
      chk($sformatf("e_fetch%0d", i), 32'(state), 32'h0);
    end
    mem_ready = 1'b1;
    settle();
    chk("e_irload", 32'(ir_load), 32'h1);
    tick();
    chk("e_exec1", 32'(state), 32'h1);
    chk("e_fault", 32'(fault), 32'h0);

    // Halt has priority over loop and extra; run pulse in EXEC1 ignored
    halt_req = 1'b1; loop_req = 1'b1; loop_init = 4'd4; extra = 1'b1; run = 1'b1;
    tick();
    halt_req = 1'b0; loop_req = 1'b0; loop_init = 4'd0; extra = 1'b0; run = 1'b0;
    settle();
    chk("h_state", 32'(state), 32'h4);
    chk("h_act",   32'(loop_active), 32'h0);
    chk("h_cnt",   32'(loop_cnt), 32'h0);
    chk("h_fault", 32'(fault), 32'h0);
    tick();
    chk("h_stay", 32'(state), 32'h4);
    run = 1'b1;
    tick(); run = 1'b0;
    chk("h_resume", 32'(state), 32'h0);

    // Reset on the second repeat cycle of a 5-cycle loop
    loop_req = 1'b1; loop_init = 4'd5;
    tick(); chk("r_first", 32'(state), 32'h1);
    tick(); chk("r_rep1_cnt", 32'(loop_cnt), 32'h4);
    tick(); chk("r_rep2_cnt", 32'(loop_cnt), 32'h3);
    rst = 1'b1;
    tick(); rst = 1'b0;
    settle();
    chk("r_state", 32'(state), 32'h0);
    chk("r_cnt",   32'(loop_cnt), 32'h0);
    chk("r_act",   32'(loop_active), 32'h0);

    // loop_init=1 behaves as a non-loop instruction
    loop_init = 4'd1;
    tick(); chk("o_exec1", 32'(state), 32'h1);
    tick(); chk("o_fetch", 32'(state), 32'h0);
    chk("o_act", 32'(loop_active), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
